// File: rtl/ps2_tx_pkg.sv
// ps2_tx_pkg: shared states, command bytes and parity helper for the PS/2 host transmitter
package ps2_tx_pkg;
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE} state_e;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction
endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: two-flop synchronizer for PS/2 clock/data plus registered falling-edge detect
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic clk_sync_o,
  output logic dat_sync_o,
  output logic fall_o
);
  logic [1:0] clk_q, dat_q;
  logic       clk_prev_q;
  // idle bus is high, so synchronizer stages reset to 1 to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q      <= 2'b11;
      dat_q      <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_q      <= {clk_q[0], ps2_clk_i};
      dat_q      <= {dat_q[0], ps2_dat_i};
      clk_prev_q <= clk_q[1];
    end
  end
  assign clk_sync_o = clk_q[1];
  assign dat_sync_o = dat_q[1];
  assign fall_o     = clk_prev_q & ~clk_q[1];
endmodule

// File: rtl/ps2_command_sender.sv
// ps2_command_sender: host-to-device PS/2 command transmitter with ack check and edge timeouts
module ps2_command_sender
  import ps2_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES     = 5000,
  parameter int FIRST_EDGE_CYCLES  = 750000,
  parameter int BIT_TIMEOUT_CYCLES = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       send_cmd,
  input  logic [7:0] cmd_data,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       cmd_sent,
  output logic       error,
  output logic       err_noack,
  output logic       err_timeout
);
  localparam int MAXC = (FIRST_EDGE_CYCLES > BIT_TIMEOUT_CYCLES)
                      ? ((FIRST_EDGE_CYCLES > INHIBIT_CYCLES) ? FIRST_EDGE_CYCLES : INHIBIT_CYCLES)
                      : ((BIT_TIMEOUT_CYCLES > INHIBIT_CYCLES) ? BIT_TIMEOUT_CYCLES : INHIBIT_CYCLES);
  localparam int TW = $clog2(MAXC + 1);
  state_e          state_q;
  logic            busy_q, cmd_sent_q, error_q, err_noack_q, err_timeout_q;
  logic            clk_oe_q, dat_oe_q, parity_q;
  logic [7:0]      shift_q;
  logic [3:0]      bit_cnt_q;
  logic [TW-1:0]   timer_q;
  logic            clk_sync, dat_sync, fall, expired;
  ps2_line_sync u_sync (
    .clk        (CLOCK_50),
    .rst        (reset),
    .ps2_clk_i  (PS2_CLK),
    .ps2_dat_i  (PS2_DAT),
    .clk_sync_o (clk_sync),
    .dat_sync_o (dat_sync),
    .fall_o     (fall)
  );
  assign expired = (state_q inside {SEND, ACK, WAIT_IDLE}) && !fall && timer_q <= TW'(1);
  // transfer sequencer: inhibit, request-to-send, shift on device falling edges, ack, bus idle
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      cmd_sent_q    <= 1'b0;
      error_q       <= 1'b0;
      err_noack_q   <= 1'b0;
      err_timeout_q <= 1'b0;
      clk_oe_q      <= 1'b0;
      dat_oe_q      <= 1'b0;
      parity_q      <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      timer_q       <= '0;
    end else begin
      cmd_sent_q <= 1'b0;
      error_q    <= 1'b0;
      if (expired) begin
        err_timeout_q <= 1'b1;
        error_q       <= 1'b1;
        busy_q        <= 1'b0;
        clk_oe_q      <= 1'b0;
        dat_oe_q      <= 1'b0;
        state_q       <= IDLE;
      end else begin
        case (state_q)
          IDLE: if (send_cmd) begin
            shift_q       <= cmd_data;
            parity_q      <= odd_parity(cmd_data);
            err_noack_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            bit_cnt_q     <= '0;
            timer_q       <= TW'(INHIBIT_CYCLES - 1);
            clk_oe_q      <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= INHIBIT;
          end
          INHIBIT: if (timer_q <= TW'(1)) begin
            dat_oe_q <= 1'b1;
            state_q  <= RTS;
          end else timer_q <= timer_q - TW'(1);
          RTS: begin
            clk_oe_q <= 1'b0;
            timer_q  <= TW'(FIRST_EDGE_CYCLES);
            state_q  <= SEND;
          end
          SEND: begin
            timer_q <= fall ? TW'(BIT_TIMEOUT_CYCLES) : timer_q - TW'(1);
            if (fall) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q < 4'd8) begin
                dat_oe_q <= ~shift_q[0];
                shift_q  <= shift_q >> 1;
              end else if (bit_cnt_q == 4'd8) dat_oe_q <= ~parity_q;
              else begin
                dat_oe_q <= 1'b0;
                state_q  <= ACK;
              end
            end
          end
          ACK: begin
            timer_q <= fall ? TW'(BIT_TIMEOUT_CYCLES) : timer_q - TW'(1);
            if (fall && !dat_sync) state_q <= WAIT_IDLE;
            else if (fall) begin
              err_noack_q <= 1'b1;
              error_q     <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end
          end
          WAIT_IDLE: begin
            timer_q <= fall ? TW'(BIT_TIMEOUT_CYCLES) : timer_q - TW'(1);
            if (clk_sync && dat_sync) begin
              cmd_sent_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign PS2_CLK     = clk_oe_q ? 1'b0 : 1'bz;
  assign PS2_DAT     = dat_oe_q ? 1'b0 : 1'bz;
  assign busy        = busy_q;
  assign cmd_sent    = cmd_sent_q;
  assign error       = error_q;
  assign err_noack   = err_noack_q;
  assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_ps2_command_sender.sv
// tb_ps2_command_sender: device model plus scoreboard of completion events for the PS/2 sender
module tb_ps2_command_sender;
  localparam int INH = 100;
  localparam int FE  = 400;
  localparam int BT  = 300;
  localparam int H   = 40;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       send_cmd = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  wire        ps2_clk, ps2_dat;
  logic       busy, cmd_sent, error, err_noack, err_timeout;
  logic [9:0] obs;
  logic [4:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk ? 1'bz : 1'b0;
  assign ps2_dat = dev_dat ? 1'bz : 1'b0;
  always #5 clk = ~clk;
  ps2_command_sender #(
    .INHIBIT_CYCLES     (INH),
    .FIRST_EDGE_CYCLES  (FE),
    .BIT_TIMEOUT_CYCLES (BT)
  ) dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .send_cmd    (send_cmd),
    .cmd_data    (cmd_data),
    .PS2_CLK     (ps2_clk),
    .PS2_DAT     (ps2_dat),
    .busy        (busy),
    .cmd_sent    (cmd_sent),
    .error       (error),
    .err_noack   (err_noack),
    .err_timeout (err_timeout)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // scoreboard monitor: every completion/abort pulse must match the next queued expectation
  always @(negedge clk) begin
    if (cmd_sent === 1'b1 || error === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got {busy,sent,err,noack,tmo}=%b expected none",
                 {busy, cmd_sent, error, err_noack, err_timeout});
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        if ({busy, cmd_sent, error, err_noack, err_timeout} !== e) begin
          errors++;
          $display("FAIL event: got {busy,sent,err,noack,tmo}=%b expected %b",
                   {busy, cmd_sent, error, err_noack, err_timeout}, e);
        end
      end
    end
  end
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    send_cmd = 1'b1;
    cmd_data = b;
    @(negedge clk);
    send_cmd = 1'b0;
    chk("busy_after_accept", busy, 1);
    chk("flags_cleared", {err_noack, err_timeout}, 0);
  endtask
  task automatic inhibit();
    int lo = 0;
    for (int i = 0; i < 4 * INH; i++) begin
      if (ps2_clk !== 1'b0) break;
      lo++;
      @(negedge clk);
    end
    chk("inhibit_len", lo, INH);
    chk("start_bit", ps2_dat, 0);
  endtask
  task automatic dev_edges(input int n, input bit poke);
    for (int e = 1; e <= n; e++) begin
      repeat (H) @(negedge clk);
      dev_clk = 1'b0;
      if (poke && e == 4) begin
        cmd_data = 8'h00;
        send_cmd = 1'b1;
        @(negedge clk);
        send_cmd = 1'b0;
        repeat (H - 1) @(negedge clk);
      end else repeat (H) @(negedge clk);
      obs[e-1] = ps2_dat;
      dev_clk = 1'b1;
    end
  endtask
  task automatic dev_ack(input bit ack);
    repeat (H / 2) @(negedge clk);
    if (ack) dev_dat = 1'b0;
    repeat (H / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (H) @(negedge clk);
    dev_clk = 1'b1;
    repeat (4) @(negedge clk);
    dev_dat = 1'b1;
  endtask
  task automatic wait_not_busy();
    for (int i = 0; i < 200 && busy !== 1'b0; i++) @(negedge clk);
    chk("busy_low", busy, 0);
  endtask
  task automatic full(input logic [7:0] b, input bit ack, input bit poke);
    exp_q.push_back(ack ? 5'b01000 : 5'b00110);
    send(b);
    inhibit();
    dev_edges(10, poke);
    for (int i = 0; i < 8; i++) chk($sformatf("data_bit%0d", i), obs[i], b[i]);
    chk("parity_bit", obs[8], ~^b);
    chk("stop_bit", obs[9], 1);
    dev_ack(ack);
    wait_not_busy();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {busy, cmd_sent, error, err_noack, err_timeout}, 0);
    chk("rst_lines", {ps2_clk, ps2_dat}, 2'b11);
    full(8'hED, 1'b1, 1'b0);
    full(8'hF4, 1'b1, 1'b0);
    full(8'hFF, 1'b0, 1'b0);
    chk("noack_flag", err_noack, 1);
    chk("noack_lines", {ps2_clk, ps2_dat}, 2'b11);
    begin
      int n = 0;
      exp_q.push_back(5'b00101);
      send(8'hF4);
      inhibit();
      while (error !== 1'b1 && n < 4 * FE) begin
        @(negedge clk);
        n++;
      end
      chk("timeout_delay", n, FE);
      chk("timeout_flag", err_timeout, 1);
      chk("timeout_lines", {ps2_clk, ps2_dat}, 2'b11);
    end
    full(8'hED, 1'b1, 1'b0);
    full(8'hF4, 1'b1, 1'b1);
    repeat (INH + 20) @(negedge clk);
    chk("no_requeue_busy", busy, 0);
    chk("no_requeue_clk", ps2_clk, 1);
    send(8'hFF);
    inhibit();
    dev_edges(3, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_lines", {ps2_clk, ps2_dat}, 2'b11);
    chk("midrst_busy", busy, 0);
    repeat (5) @(negedge clk);
    full(8'hED, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish within 200000 cycles");
    $fatal(1, "watchdog expired");
  end
endmodule
